// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default constants for the memory arbiter slice.
//   state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   owner_t : access owner encoding (OWN_CPU=0, OWN_DMA=1)
//   DEF_*   : default values for the arbiter parameters
//   CNT_W   : width of the BUSY-cycle counter (covers TIMEOUT up to 255)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int DEF_ADDR_W  = 12;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_TIMEOUT = 15;
   localparam int CNT_W       = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// arb_timeout_cnt
// Counts BUSY cycles of the arbiter and flags the last allowed one.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  asynchronous active-low reset
//   clear   in  return the count to 0 (held while the arbiter is not BUSY)
//   enable  in  count this cycle (arbiter is BUSY)
//   expired out high in the BUSY cycle whose count equals TIMEOUT-1
// -----------------------------------------------------------------------------
module arb_timeout_cnt
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Saturate at LAST so the count can never wrap back below it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && (cnt != LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester (CPU, DMA) single-port memory arbiter with BUSY timeout.
// One access at a time: IDLE grants and latches the request, BUSY drives the
// memory until memReady or timeout, RESP pulses the owner's ack for one cycle.
//
// Handshake: a requester raises xReq with stable command fields and holds it
// until its xAck pulse; the command is captured at the grant edge, so later
// changes on the requester inputs do not affect the access. The memory side
// sees memReq high for the whole access and completes it with memReady.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   cpuReq/Write/Addr/Wdata, cpuAck CPU requester
//   dmaReq/Write/Addr/Wdata, dmaAck DMA requester
//   rdata, err                     read data / timeout flag, valid with an ack
//   memReq/Write/Addr/Wdata        memory command
//   memRdata, memReady             memory response
//   busy                           high whenever the FSM is not IDLE
//
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin conflict
// resolution; without it the CPU always wins a conflict.
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpuReq,
   input  logic              cpuWrite,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [DATA_W-1:0] cpuWdata,
   output logic              cpuAck,
   input  logic              dmaReq,
   input  logic              dmaWrite,
   input  logic [ADDR_W-1:0] dmaAddr,
   input  logic [DATA_W-1:0] dmaWdata,
   output logic              dmaAck,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              memReq,
   output logic              memWrite,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memReady,
   output logic              busy
);

   state_t            state, state_nxt;
   owner_t            owner;
   owner_t            grant_own;
   logic              lat_write;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              expired;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_t            last_grant;
`endif

   // Conflict resolution; a lone request always wins.
   always_comb begin
      grant_own = OWN_CPU;
      if (cpuReq && dmaReq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         grant_own = (last_grant == OWN_CPU) ? OWN_DMA : OWN_CPU;
`else
         grant_own = OWN_CPU;
`endif
      end else if (dmaReq) begin
         grant_own = OWN_DMA;
      end
   end

   arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != BUSY),
      .enable  (state == BUSY),
      .expired (expired)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and outputs. memReady wins over expiry in the same cycle.
   always_comb begin
      state_nxt = state;
      memReq    = 1'b0;
      memWrite  = 1'b0;
      cpuAck    = 1'b0;
      dmaAck    = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (cpuReq || dmaReq) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            memReq   = 1'b1;
            memWrite = lat_write;
            if (memReady || expired) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            cpuAck    = (owner == OWN_CPU);
            dmaAck    = (owner == OWN_DMA);
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign memAddr  = lat_addr;
   assign memWdata = lat_wdata;

   // Grant capture and response datapath.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner      <= OWN_CPU;
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rdata      <= '0;
         err        <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant <= OWN_DMA;
`endif
      end else begin
         if ((state == IDLE) && (cpuReq || dmaReq)) begin
            owner     <= grant_own;
            lat_write <= (grant_own == OWN_CPU) ? cpuWrite : dmaWrite;
            lat_addr  <= (grant_own == OWN_CPU) ? cpuAddr  : dmaAddr;
            lat_wdata <= (grant_own == OWN_CPU) ? cpuWdata : dmaWdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= grant_own;
`endif
         end
         if (state == BUSY) begin
            if (memReady) begin
               if (!lat_write) begin
                  rdata <= memRdata;
               end
               err <= 1'b0;
            end else if (expired) begin
               err   <= 1'b1;
               rdata <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: a per-cycle vector table for single
// accesses and conflicts, then hand-written timeout, timeout-boundary and
// reset-in-BUSY sequences. Inputs are driven and outputs compared on the
// falling clock edge; the design has no input-to-output combinational path.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        cpuReq, cpuWrite, cpuAck;
   logic [11:0] cpuAddr;
   logic [15:0] cpuWdata;
   logic        dmaReq, dmaWrite, dmaAck;
   logic [11:0] dmaAddr;
   logic [15:0] dmaWdata;
   logic [15:0] rdata;
   logic        err;
   logic        memReq, memWrite;
   logic [11:0] memAddr;
   logic [15:0] memWdata;
   logic [15:0] memRdata;
   logic        memReady;
   logic        busy;

   int checks = 0;
   int errors = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   mem_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .cpuReq   (cpuReq),
      .cpuWrite (cpuWrite),
      .cpuAddr  (cpuAddr),
      .cpuWdata (cpuWdata),
      .cpuAck   (cpuAck),
      .dmaReq   (dmaReq),
      .dmaWrite (dmaWrite),
      .dmaAddr  (dmaAddr),
      .dmaWdata (dmaWdata),
      .dmaAck   (dmaAck),
      .rdata    (rdata),
      .err      (err),
      .memReq   (memReq),
      .memWrite (memWrite),
      .memAddr  (memAddr),
      .memWdata (memWdata),
      .memRdata (memRdata),
      .memReady (memReady),
      .busy     (busy)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   typedef struct {
      string       name;
      logic        creq, cwr;
      logic [11:0] caddr;
      logic [15:0] cwd;
      logic        dreq, dwr;
      logic [11:0] daddr;
      logic [15:0] dwd;
      logic        mrdy;
      logic [15:0] mrd;
      logic        e_busy, e_mreq, e_cack, e_dack;
      logic        chk_mem;
      logic        e_mwr;
      logic [11:0] e_maddr;
      logic [15:0] e_mwd;
      logic [15:0] e_rdata;
      logic        e_err;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t v(
      string nm, logic creq, logic cwr, logic [11:0] caddr, logic [15:0] cwd,
      logic dreq, logic dwr, logic [11:0] daddr, logic [15:0] dwd,
      logic mrdy, logic [15:0] mrd,
      logic eb, logic em, logic eca, logic eda,
      logic chk, logic emw, logic [11:0] ema, logic [15:0] emd,
      logic [15:0] erd, logic eer);
      vec_t r;
      r.name = nm; r.creq = creq; r.cwr = cwr; r.caddr = caddr; r.cwd = cwd;
      r.dreq = dreq; r.dwr = dwr; r.daddr = daddr; r.dwd = dwd;
      r.mrdy = mrdy; r.mrd = mrd;
      r.e_busy = eb; r.e_mreq = em; r.e_cack = eca; r.e_dack = eda;
      r.chk_mem = chk; r.e_mwr = emw; r.e_maddr = ema; r.e_mwd = emd;
      r.e_rdata = erd; r.e_err = eer;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      cpuReq = 0; cpuWrite = 0; cpuAddr = '0; cpuWdata = '0;
      dmaReq = 0; dmaWrite = 0; dmaAddr = '0; dmaWdata = '0;
      memReady = 0; memRdata = '0;
   endtask

   task automatic apply(input vec_t r);
      cpuReq = r.creq; cpuWrite = r.cwr; cpuAddr = r.caddr; cpuWdata = r.cwd;
      dmaReq = r.dreq; dmaWrite = r.dwr; dmaAddr = r.daddr; dmaWdata = r.dwd;
      memReady = r.mrdy; memRdata = r.mrd;
      chk({r.name, ".busy"},   32'(busy),   32'(r.e_busy));
      chk({r.name, ".memReq"}, 32'(memReq), 32'(r.e_mreq));
      chk({r.name, ".cpuAck"}, 32'(cpuAck), 32'(r.e_cack));
      chk({r.name, ".dmaAck"}, 32'(dmaAck), 32'(r.e_dack));
      chk({r.name, ".rdata"},  32'(rdata),  32'(r.e_rdata));
      chk({r.name, ".err"},    32'(err),    32'(r.e_err));
      if (r.chk_mem) begin
         chk({r.name, ".memWrite"}, 32'(memWrite), 32'(r.e_mwr));
         chk({r.name, ".memAddr"},  32'(memAddr),  32'(r.e_maddr));
         chk({r.name, ".memWdata"}, 32'(memWdata), 32'(r.e_mwd));
      end
   endtask

   initial begin
      // Table: one row per cycle, outputs are those of that cycle.
      // CPU read 0x010, memReady in the first BUSY cycle.
      vt.push_back(v("a_idle",1,0,12'h010,16'h0,0,0,12'h0,16'h0,0,16'h0,    0,0,0,0, 0,0,12'h0,16'h0,     16'h0000,0));
      vt.push_back(v("a_busy",1,0,12'h010,16'h0,0,0,12'h0,16'h0,1,16'hBEEF, 1,1,0,0, 1,0,12'h010,16'h0000,16'h0000,0));
      vt.push_back(v("a_resp",1,0,12'h010,16'h0,0,0,12'h0,16'h0,0,16'h0,    1,0,1,0, 0,0,12'h0,16'h0,     16'hBEEF,0));
      vt.push_back(v("a_done",0,0,12'h0,16'h0,0,0,12'h0,16'h0,0,16'h0,      0,0,0,0, 0,0,12'h0,16'h0,     16'hBEEF,0));
      // DMA write 0x3FF/0x1234, requester inputs change after grant,
      // memReady in the 4th BUSY cycle; rdata must hold.
      vt.push_back(v("b_idle",0,0,12'h0,16'h0,1,1,12'h3FF,16'h1234,0,16'h0, 0,0,0,0, 0,0,12'h0,16'h0,       16'hBEEF,0));
      vt.push_back(v("b_busy1",0,0,12'h0,16'h0,1,0,12'h555,16'hFFFF,0,16'h0, 1,1,0,0, 1,1,12'h3FF,16'h1234,  16'hBEEF,0));
      vt.push_back(v("b_busy2",0,0,12'h0,16'h0,1,0,12'h555,16'hFFFF,0,16'h0, 1,1,0,0, 1,1,12'h3FF,16'h1234,  16'hBEEF,0));
      vt.push_back(v("b_busy3",0,0,12'h0,16'h0,1,0,12'h555,16'hFFFF,0,16'h0, 1,1,0,0, 1,1,12'h3FF,16'h1234,  16'hBEEF,0));
      vt.push_back(v("b_busy4",0,0,12'h0,16'h0,1,0,12'h555,16'hFFFF,1,16'hAAAA, 1,1,0,0, 1,1,12'h3FF,16'h1234,16'hBEEF,0));
      vt.push_back(v("b_resp",0,0,12'h0,16'h0,1,0,12'h555,16'hFFFF,0,16'h0,  1,0,0,1, 0,0,12'h0,16'h0,       16'hBEEF,0));
      vt.push_back(v("b_done",0,0,12'h0,16'h0,0,0,12'h0,16'h0,0,16'h0,       0,0,0,0, 0,0,12'h0,16'h0,       16'hBEEF,0));
      // Both requesters held high: three back-to-back accesses.
      vt.push_back(v("c_idle1",1,0,12'h0A1,16'h00C1,1,0,12'h0B2,16'h00D2,1,16'h1357, 0,0,0,0, 0,0,12'h0,16'h0, 16'hBEEF,0));
      vt.push_back(v("c_busy1",1,0,12'h0A1,16'h00C1,1,0,12'h0B2,16'h00D2,1,16'h1357, 1,1,0,0, 1,0,12'h0A1,16'h00C1, 16'hBEEF,0));
      vt.push_back(v("c_resp1",1,0,12'h0A1,16'h00C1,1,0,12'h0B2,16'h00D2,1,16'h1357, 1,0,1,0, 0,0,12'h0,16'h0, 16'h1357,0));
      vt.push_back(v("c_idle2",1,0,12'h0A1,16'h00C1,1,0,12'h0B2,16'h00D2,1,16'h1357, 0,0,0,0, 0,0,12'h0,16'h0, 16'h1357,0));
      vt.push_back(v("c_busy2",1,0,12'h0A1,16'h00C1,1,0,12'h0B2,16'h00D2,1,16'h1357, 1,1,0,0, 1,0,
                     RR ? 12'h0B2 : 12'h0A1, RR ? 16'h00D2 : 16'h00C1, 16'h1357,0));
      vt.push_back(v("c_resp2",1,0,12'h0A1,16'h00C1,1,0,12'h0B2,16'h00D2,1,16'h1357, 1,0,!RR,RR, 0,0,12'h0,16'h0, 16'h1357,0));
      vt.push_back(v("c_idle3",1,0,12'h0A1,16'h00C1,1,0,12'h0B2,16'h00D2,1,16'h1357, 0,0,0,0, 0,0,12'h0,16'h0, 16'h1357,0));
      vt.push_back(v("c_busy3",1,0,12'h0A1,16'h00C1,1,0,12'h0B2,16'h00D2,1,16'h1357, 1,1,0,0, 1,0,12'h0A1,16'h00C1, 16'h1357,0));
      vt.push_back(v("c_resp3",1,0,12'h0A1,16'h00C1,1,0,12'h0B2,16'h00D2,1,16'h1357, 1,0,1,0, 0,0,12'h0,16'h0, 16'h1357,0));
      vt.push_back(v("c_done",0,0,12'h0,16'h0,0,0,12'h0,16'h0,0,16'h0,              0,0,0,0, 0,0,12'h0,16'h0, 16'h1357,0));

      // Reset state.
      drive_idle();
      rst = 1'b0;
      @(negedge clk);
      chk("rst.busy",     32'(busy),     32'h0);
      chk("rst.memReq",   32'(memReq),   32'h0);
      chk("rst.memWrite", 32'(memWrite), 32'h0);
      chk("rst.memAddr",  32'(memAddr),  32'h0);
      chk("rst.memWdata", 32'(memWdata), 32'h0);
      chk("rst.cpuAck",   32'(cpuAck),   32'h0);
      chk("rst.dmaAck",   32'(dmaAck),   32'h0);
      chk("rst.rdata",    32'(rdata),    32'h0);
      chk("rst.err",      32'(err),      32'h0);
      rst = 1'b1;

      foreach (vt[i]) begin
         @(negedge clk);
         apply(vt[i]);
      end

      // Timeout: memReady never arrives -> exactly 15 BUSY cycles, then ack
      // with err=1 and rdata cleared.
      @(negedge clk);
      drive_idle();
      cpuReq = 1; cpuAddr = 12'h123;
      chk("to.idle", 32'(busy), 32'h0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk($sformatf("to.busy%0d.memReq", i), 32'(memReq), 32'h1);
         chk($sformatf("to.busy%0d.cpuAck", i), 32'(cpuAck), 32'h0);
      end
      @(negedge clk);
      chk("to.resp.cpuAck", 32'(cpuAck), 32'h1);
      chk("to.resp.err",    32'(err),    32'h1);
      chk("to.resp.rdata",  32'(rdata),  32'h0);
      chk("to.resp.memReq", 32'(memReq), 32'h0);
      cpuReq = 0;

      // Boundary: memReady exactly on the 15th BUSY cycle wins over expiry.
      @(negedge clk);
      chk("tb.idle", 32'(busy), 32'h0);
      cpuReq = 1; cpuAddr = 12'h124;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 14) begin
            memReady = 1; memRdata = 16'hCAFE;
         end
         chk($sformatf("tb.busy%0d.memReq", i), 32'(memReq), 32'h1);
      end
      @(negedge clk);
      memReady = 0; memRdata = '0;
      chk("tb.resp.cpuAck", 32'(cpuAck), 32'h1);
      chk("tb.resp.err",    32'(err),    32'h0);
      chk("tb.resp.rdata",  32'(rdata),  32'hCAFE);
      cpuReq = 0;

      // Reset in the 2nd BUSY cycle: abandoned with no ack; the held request
      // is granted at the first edge after release.
      @(negedge clk);
      cpuReq = 1; cpuAddr = 12'h2AB;
      @(negedge clk);
      chk("rb.busy1.memReq", 32'(memReq), 32'h1);
      @(negedge clk);
      chk("rb.busy2.memReq", 32'(memReq), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("rb.async.memReq", 32'(memReq), 32'h0);
      chk("rb.async.busy",   32'(busy),   32'h0);
      chk("rb.async.rdata",  32'(rdata),  32'h0);
      chk("rb.async.err",    32'(err),    32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rb.held%0d.cpuAck", i), 32'(cpuAck), 32'h0);
         chk($sformatf("rb.held%0d.busy", i),   32'(busy),   32'h0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rb.regrant.memReq",  32'(memReq),  32'h1);
      chk("rb.regrant.memAddr", 32'(memAddr), 32'h2AB);
      memReady = 1; memRdata = 16'h0F0F;
      @(negedge clk);
      memReady = 0;
      chk("rb.resp.cpuAck", 32'(cpuAck), 32'h1);
      chk("rb.resp.rdata",  32'(rdata),  32'h0F0F);
      cpuReq = 0;
      @(negedge clk);
      chk("rb.done.busy", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
